serial_sub: RTL



---
 rtl/serial_sub.sv | 80 ++++++++
 1 files changed

// File: rtl/serial_sub.sv
// serial_sub: LSB-first bit-serial subtractor d = a - b - bin; optional signed overflow flag under SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic br, x, br_n, last;
`ifdef SERIAL_SUB_OVF_EN
  logic sd;
`endif
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = state == DONE;
  always_comb begin
    x       = sa[0] ^ sb[0] ^ br;
    br_n    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last    = cnt == CW'(WIDTH - 1);
    state_n = state == IDLE  ? (in_valid ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) :
                               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sd    <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        sa  <= a;
        sb  <= b;
        br  <= bin;
        cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
        sd  <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end
      if (state == SHIFT) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= br_n;
        d   <= {x, d[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        if (last) begin
          bout <= br_n;
`ifdef SERIAL_SUB_OVF_EN
          // in the last cycle sa[0] is the minuend sign and x the result sign
          ovf  <= sd & (sa[0] ^ x);
`endif
        end
      end
    end
  end
endmodule
